// File: rtl/sw_seq_feeder.sv
// Holds S/T symbol sequences, streams them to the aligner as one
// contiguous valid burst, then waits for the aligner's finish/score.
module sw_seq_feeder #(
    parameter int unsigned SEQ_LEN = 256,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic        wr_sel,
    input  logic [7:0]  wr_addr,
    input  logic [1:0]  wr_data,
    input  logic        start,
    output logic        busy,
    output logic [1:0]  data_s,
    output logic [1:0]  data_t,
    output logic        valid,
    input  logic        finish,
    input  logic [11:0] max,
    output logic        done,
    output logic        err,
    output logic [11:0] result
);

    localparam int unsigned IW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(SEQ_LEN - 1);
    localparam logic [CW-1:0] TMO_CNT  = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic            busy_d, valid_d, done_d, err_d;
    logic [1:0]      data_s_d, data_t_d;
    logic [11:0]     result_d;

    logic [1:0]      s_mem [SEQ_LEN];
    logic [1:0]      t_mem [SEQ_LEN];

    logic            idle_c, wr_ok_c, wr_hit_c;
    logic [IW-1:0]   rd_idx_c;
    logic [1:0]      rd_s_c, rd_t_c;

    // Host writes land only while no job is in flight; the next beat's read
    // forwards a same-cycle write so a write issued with start is streamed.
    assign idle_c   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign wr_ok_c  = wr_en && idle_c && (32'(wr_addr) < SEQ_LEN);
    assign rd_idx_c = (state_q == ST_STREAM) ? idx_q + 1'b1 : '0;
    assign wr_hit_c = wr_ok_c && (IW'(wr_addr) == rd_idx_c);
    assign rd_s_c   = (wr_hit_c && !wr_sel) ? wr_data : s_mem[rd_idx_c];
    assign rd_t_c   = (wr_hit_c &&  wr_sel) ? wr_data : t_mem[rd_idx_c];

    // Sequence buffers (not reset)
    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            if (wr_sel) t_mem[IW'(wr_addr)] <= wr_data;
            else        s_mem[IW'(wr_addr)] <= wr_data;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wcnt_d   = wcnt_q;
        busy_d   = busy;
        valid_d  = 1'b0;
        data_s_d = 2'b00;
        data_t_d = 2'b00;
        done_d   = done;
        err_d    = err;
        result_d = result;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_STREAM;
                    idx_d    = '0;
                    wcnt_d   = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    result_d = '0;
                    valid_d  = 1'b1;
                    data_s_d = rd_s_c;
                    data_t_d = rd_t_c;
                end
            end
            ST_STREAM: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_WAIT;
                    wcnt_d  = '0;
                end else begin
                    idx_d    = idx_q + 1'b1;
                    valid_d  = 1'b1;
                    data_s_d = rd_s_c;
                    data_t_d = rd_t_c;
                end
            end
            ST_WAIT: begin
                if (finish) begin
                    state_d  = ST_DONE;
                    result_d = max;
                    done_d   = 1'b1;
                    err_d    = 1'b0;
                    busy_d   = 1'b0;
                end else if (wcnt_q == TMO_CNT) begin
                    state_d  = ST_DONE;
                    result_d = '0;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                    busy_d   = 1'b0;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            wcnt_q  <= '0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            data_s  <= 2'b00;
            data_t  <= 2'b00;
            done    <= 1'b0;
            err     <= 1'b0;
            result  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            busy    <= busy_d;
            valid   <= valid_d;
            data_s  <= data_s_d;
            data_t  <= data_t_d;
            done    <= done_d;
            err     <= err_d;
            result  <= result_d;
        end
    end

endmodule

// File: tb/tb_sw_seq_feeder.sv
// Bench for sw_seq_feeder: timeline model plus directed job scenarios.
module tb_sw_seq_feeder;

    localparam int unsigned SEQ_LEN = 256;
    localparam int unsigned TIMEOUT = 1023;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_en, wr_sel, start, finish;
    logic [7:0]  wr_addr;
    logic [1:0]  wr_data;
    logic [11:0] max;
    logic        busy, valid, done, err;
    logic [1:0]  data_s, data_t;
    logic [11:0] result;

    int errors = 0;
    int checks = 0;

    sw_seq_feeder #(.SEQ_LEN(SEQ_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy), .data_s(data_s), .data_t(data_t), .valid(valid),
        .finish(finish), .max(max), .done(done), .err(err), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a job accepted at edge k shows beat r after edge k+r (r < SEQ_LEN);
    // WAIT cycle w is sampled at edge k+SEQ_LEN+1+w.
    logic [1:0]  s_ref [SEQ_LEN];
    logic [1:0]  t_ref [SEQ_LEN];
    logic [1:0]  s_snap [SEQ_LEN];
    logic [1:0]  t_snap [SEQ_LEN];
    int          edge_n = 0;
    int          m_k = 0;
    bit          m_active = 1'b0, m_done = 1'b0, m_err = 1'b0;
    logic [11:0] m_result = '0;

    always @(posedge clk or negedge reset_n) begin
        int n, w;
        if (!reset_n) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_err    <= 1'b0;
            m_result <= '0;
        end else begin
            n = edge_n + 1;
            edge_n <= n;
            if (!m_active) begin
                if (wr_en && 32'(wr_addr) < SEQ_LEN) begin
                    if (wr_sel) t_ref[wr_addr] <= wr_data;
                    else        s_ref[wr_addr] <= wr_data;
                end
                if (start) begin
                    s_snap <= s_ref;
                    t_snap <= t_ref;
                    if (wr_en && 32'(wr_addr) < SEQ_LEN) begin
                        if (wr_sel) t_snap[wr_addr] <= wr_data;
                        else        s_snap[wr_addr] <= wr_data;
                    end
                    m_active <= 1'b1;
                    m_k      <= n;
                    m_done   <= 1'b0;
                    m_err    <= 1'b0;
                    m_result <= '0;
                end
            end else begin
                w = n - m_k - int'(SEQ_LEN) - 1;
                if (w >= 0) begin
                    if (finish) begin
                        m_active <= 1'b0; m_done <= 1'b1; m_err <= 1'b0; m_result <= max;
                    end else if (w == int'(TIMEOUT)) begin
                        m_active <= 1'b0; m_done <= 1'b1; m_err <= 1'b1; m_result <= '0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        int rel;
        bit ev;
        logic [1:0] es, et;
        if (reset_n === 1'b1) begin
            rel = edge_n - m_k;
            ev  = m_active && rel >= 0 && rel < int'(SEQ_LEN);
            es  = 2'b00;
            et  = 2'b00;
            if (ev) begin
                es = s_snap[rel];
                et = t_snap[rel];
            end
            chk("model_busy",   busy,   m_active);
            chk("model_valid",  valid,  ev);
            chk("model_data_s", data_s, es);
            chk("model_data_t", data_t, et);
            chk("model_done",   done,   m_done);
            chk("model_err",    err,    m_err);
            chk("model_result", result, m_result);
        end
    end

    // Valid beat and burst counters
    int vcount = 0, vruns = 0;
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (valid === 1'b1) vcount <= vcount + 1;
        if (valid === 1'b1 && prev_v !== 1'b1) vruns <= vruns + 1;
        prev_v <= valid;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input int a, input logic [1:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_addr = 8'(a); wr_data = d;
        tick;
        wr_en = 1'b0;
    endtask

    // Start one job and check every beat; ends mid WAIT cycle 0
    task automatic stream_job(input bit t_rev, input bit wr_t0, input logic [1:0] t0val);
        int v0, r0;
        logic [1:0] es, et;
        v0 = vcount; r0 = vruns;
        start = 1'b1;
        if (wr_t0) begin
            wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 8'd0; wr_data = t0val;
        end
        tick;
        start = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < int'(SEQ_LEN); i++) begin
            @(negedge clk);
            es = 2'(i % 4);
            et = t_rev ? 2'(3 - i % 4) : 2'(i % 4);
            if (wr_t0 && i == 0) et = t0val;
            chk("beat_valid", valid, 1);
            chk("beat_s", data_s, es);
            chk("beat_t", data_t, et);
            if (i == 0) begin
                chk("accept_busy", busy, 1);
                chk("accept_done_clr", done, 0);
                chk("accept_err_clr", err, 0);
                chk("accept_result_clr", result, 0);
            end
            tick;
        end
        @(negedge clk);
        chk("valid_after_burst", valid, 0);
        chk("burst_beats", vcount - v0, SEQ_LEN);
        chk("burst_runs", vruns - r0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, v0, r0;
        reset_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; finish = 1'b0; max = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_data_s", data_s, 0);
        chk("rst_data_t", data_t, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_result", result, 0);

        // finish in IDLE is ignored
        tick;
        finish = 1'b1; max = 12'h321;
        tick;
        finish = 1'b0;
        @(negedge clk);
        chk("idle_finish_result", result, 0);
        chk("idle_finish_done", done, 0);
        tick;

        // Load S[i] = T[i] = i mod 4
        for (int i = 0; i < int'(SEQ_LEN); i++) begin
            wr(1'b0, i, 2'(i % 4));
            wr(1'b1, i, 2'(i % 4));
        end

        // Job 1: finish at WAIT cycle 255 with 0x800
        stream_job(1'b0, 1'b0, 2'b00);
        repeat (255) tick;
        finish = 1'b1; max = 12'h800;
        tick;
        finish = 1'b0; max = '0;
        @(negedge clk);
        chk("j1_result", result, 12'h800);
        chk("j1_done", done, 1);
        chk("j1_err", err, 0);
        chk("j1_busy", busy, 0);
        tick;

        // Job 2: timeout after 1024 WAIT cycles
        stream_job(1'b0, 1'b0, 2'b00);
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            tick;
            n++;
        end
        chk("j2_wait_cycles", n, TIMEOUT + 1);
        @(negedge clk);
        chk("j2_done", done, 1);
        chk("j2_err", err, 1);
        chk("j2_result", result, 0);
        chk("j2_busy", busy, 0);
        tick;
        finish = 1'b1; max = 12'h5A5;
        tick;
        finish = 1'b0;
        @(negedge clk);
        chk("j2_late_finish_result", result, 0);
        chk("j2_late_finish_err", err, 1);
        tick;

        // Job 3: start, writes and finish during STREAM are ignored
        v0 = vcount; r0 = vruns;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (10) tick;
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 8'd50; wr_data = 2'd3;
        tick;
        wr_sel = 1'b1; wr_addr = 8'd60; wr_data = 2'd3;
        tick;
        wr_en = 1'b0; start = 1'b0;
        repeat (8) tick;
        finish = 1'b1; max = 12'h777;
        tick;
        finish = 1'b0;
        n = 0;
        while (valid === 1'b1 && n < 400) begin
            tick;
            n++;
        end
        chk("j3_stream_end", valid, 0);
        chk("j3_beats", vcount - v0, SEQ_LEN);
        chk("j3_runs", vruns - r0, 1);
        chk("j3_still_busy", busy, 1);
        chk("j3_not_done", done, 0);
        finish = 1'b1; max = 12'h001;
        tick;
        finish = 1'b0;
        @(negedge clk);
        chk("j3_result", result, 12'h001);
        chk("j3_done", done, 1);
        tick;

        // Job 4: reset at beat 100, then a full job from index 0
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (100) tick;
        chk("j4_pre_reset_valid", valid, 1);
        chk("j4_pre_reset_s", data_s, 0);
        reset_n = 1'b0;
        #1;
        chk("j4_reset_valid", valid, 0);
        chk("j4_reset_busy", busy, 0);
        chk("j4_reset_data_s", data_s, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        v0 = vcount;
        repeat (3) tick;
        chk("j4_idle_no_beats", vcount - v0, 0);
        chk("j4_idle_busy", busy, 0);
        stream_job(1'b0, 1'b0, 2'b00);
        repeat (3) tick;
        finish = 1'b1; max = 12'h0AB;
        tick;
        finish = 1'b0;
        @(negedge clk);
        chk("j4_result", result, 12'h0AB);
        chk("j4_done", done, 1);
        tick;

        // Job 5: back-to-back from DONE with T rewritten, T[0] written with start
        chk("j5_done_before", done, 1);
        for (int i = 0; i < int'(SEQ_LEN); i++) wr(1'b1, i, 2'(3 - i % 4));
        stream_job(1'b1, 1'b1, 2'd2);
        tick;
        finish = 1'b1; max = 12'hFFF;
        tick;
        finish = 1'b0;
        @(negedge clk);
        chk("j5_result", result, 12'hFFF);
        chk("j5_done", done, 1);
        chk("j5_err", err, 0);
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
